// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words
// and writes them to consecutive addresses while holding the CPU.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        bcnt_q;
  logic [31:0]       word_q;
  logic              error_q;
  logic              accept;
  logic              last_word;
  logic              start_ok;

  assign accept    = (state_q == LOAD) && byte_valid;
  assign last_word = ({1'b0, idx_q} + CNT_ONE) == count_q;
  assign start_ok  = (state_q == IDLE) && start && (word_count <= DEPTH_W);

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = (word_count == '0) ? FINISH : LOAD;
      end
      LOAD: begin
        if (accept && bcnt_q == 2'd3) state_d = WRITE;
      end
      WRITE:   state_d = last_word ? FINISH : LOAD;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        if (start_ok) begin
          error_q <= 1'b0;
          count_q <= word_count;
          idx_q   <= '0;
          bcnt_q  <= '0;
        end else begin
          error_q <= 1'b1;
        end
      end
      // Shifting left leaves the first byte of each group in [31:24].
      if (accept) begin
        word_q <= {word_q[23:0], byte_in};
        bcnt_q <= bcnt_q + 2'd1;
      end
      if (state_q == WRITE && !last_word) idx_q <= idx_q + IDX_ONE;
    end
  end

  assign byte_ready = (state_q == LOAD);
  assign we         = (state_q == WRITE);
  assign done       = (state_q == FINISH);
  assign cpu_hold   = (state_q != IDLE);
  assign waddr      = idx_q;
  assign wdata      = word_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a session-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_imem_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              start      = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [7:0]        byte_in    = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, we, cpu_hold, done, error;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    n_checks++;
    n_errors++;
    $display("FAIL timeout %s at %0t", what, $time);
  endtask

  // Session-level reference: a session is a list of byte groups; each full group
  // of four produces one write cycle, the last write is followed by one done cycle.
  bit          m_active, m_wr_pend, m_done_pend, m_err, m_just_reset;
  int          m_count, m_written, m_wr_addr;
  logic [31:0] m_wr_data;
  logic [7:0]  m_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_wr_pend = 0; m_done_pend = 0; m_err = 0; m_just_reset = 1;
      m_q.delete();
    end else begin
      m_just_reset = 0;
      if (m_done_pend) begin
        m_done_pend = 0;
        m_active    = 0;
      end else if (m_wr_pend) begin
        m_wr_pend = 0;
        m_written++;
        if (m_written == m_count) m_done_pend = 1;
      end else if (m_active) begin
        if (byte_valid) begin
          m_q.push_back(byte_in);
          if (m_q.size() == 4) begin
            m_wr_pend = 1;
            m_wr_addr = m_written;
            m_wr_data = {m_q[0], m_q[1], m_q[2], m_q[3]};
            m_q.delete();
          end
        end
      end else if (start) begin
        if (int'(word_count) > DEPTH) m_err = 1;
        else begin
          m_err = 0; m_count = int'(word_count); m_written = 0; m_active = 1;
          m_q.delete();
          if (m_count == 0) m_done_pend = 1;
        end
      end
    end
  end

  typedef struct {int addr; logic [31:0] data;} wr_t;
  wr_t wr_log[$];
  int  done_cnt, hold_cnt, acc_cnt, ready_cnt, cycle, last_we_cycle, done_cycle;

  always @(negedge clk) begin
    check("byte_ready", 32'(byte_ready), 32'(m_active && !m_wr_pend && !m_done_pend));
    check("we",         32'(we),         32'(m_wr_pend));
    check("done",       32'(done),       32'(m_done_pend));
    check("cpu_hold",   32'(cpu_hold),   32'(m_active));
    check("error",      32'(error),      32'(m_err));
    if (m_wr_pend) begin
      check("waddr", 32'(waddr), m_wr_addr);
      check("wdata", wdata, m_wr_data);
    end
    if (m_just_reset) begin
      check("reset_waddr", 32'(waddr), 0);
      check("reset_wdata", wdata, 0);
    end
    cycle++;
    if (we) begin
      wr_log.push_back('{int'(waddr), wdata});
      last_we_cycle = cycle;
    end
    if (done) begin
      done_cnt++;
      done_cycle = cycle;
    end
    if (cpu_hold) hold_cnt++;
    if (byte_ready) ready_cnt++;
    if (byte_valid && byte_ready) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_log.delete();
    done_cnt = 0; hold_cnt = 0; acc_cnt = 0; ready_cnt = 0;
  endtask

  task automatic start_session(input int wc);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit took;
    byte_valid = 1'b0;
    repeat (gap) begin
      byte_in = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_in    = b;
    took       = 0;
    for (int t = 0; t < 50 && !took; t++) begin
      took = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    if (!took) timeout("send_byte");
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (cpu_hold && t < 500) begin
      tick();
      t++;
    end
    if (cpu_hold) timeout("wait_idle");
    tick();
  endtask

  task automatic expect_write(input int idx, input int addr, input logic [31:0] data);
    if (idx < wr_log.size()) begin
      check("log_addr", wr_log[idx].addr, addr);
      check("log_data", wr_log[idx].data, data);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL log_missing: write %0d absent, have %0d", idx, wr_log.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    bit aborted;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_we",    32'(we), 0);
    check("rst_hold",  32'(cpu_hold), 0);
    check("rst_done",  32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", wdata, 0);

    // Two back-to-back words, no gaps.
    clear_stats();
    start_session(2);
    send_word(32'h20020005, 0);
    send_word(32'h2003000C, 0);
    wait_idle();
    check("s1_writes", wr_log.size(), 2);
    expect_write(0, 0, 32'h20020005);
    expect_write(1, 1, 32'h2003000C);
    check("s1_done_cnt", done_cnt, 1);
    check("s1_hold_cycles", hold_cnt, 11);
    check("s1_done_latency", done_cycle - last_we_cycle, 1);

    // Empty session.
    clear_stats();
    start_session(0);
    check("s2_done_now", 32'(done), 1);
    wait_idle();
    check("s2_writes", wr_log.size(), 0);
    check("s2_done_cnt", done_cnt, 1);
    check("s2_hold_cycles", hold_cnt, 1);
    check("s2_ready_cycles", ready_cnt, 0);

    // Oversized count, then recovery.
    clear_stats();
    start_session(33);
    repeat (3) tick();
    check("s3_error", 32'(error), 1);
    check("s3_hold_cycles", hold_cnt, 0);
    check("s3_writes", wr_log.size(), 0);
    check("s3_done_cnt", done_cnt, 0);
    start_session(1);
    check("s3_error_clr", 32'(error), 0);
    send_word(32'h08000011, 0);
    wait_idle();
    check("s3b_writes", wr_log.size(), 1);
    expect_write(0, 0, 32'h08000011);

    // byte_valid pattern 1,0,0,1,0,1,1.
    clear_stats();
    start_session(1);
    send_byte(8'hAC, 0);
    send_byte(8'h02, 2);
    send_byte(8'h00, 1);
    send_byte(8'h54, 0);
    wait_idle();
    check("s4_accepts", acc_cnt, 4);
    check("s4_writes", wr_log.size(), 1);
    expect_write(0, 0, 32'hAC020054);

    // Reset after six accepted bytes.
    clear_stats();
    start_session(3);
    send_word(32'h11223344, 1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_hold", 32'(cpu_hold), 0);
    check("s5_we", 32'(we), 0);
    check("s5_wdata", wdata, 0);
    check("s5_writes", wr_log.size(), 1);
    expect_write(0, 0, 32'h11223344);
    clear_stats();
    start_session(1);
    send_word(32'hCAFE0001, 1);
    wait_idle();
    check("s5b_writes", wr_log.size(), 1);
    expect_write(0, 0, 32'hCAFE0001);

    // start pulsed mid-session with a different count.
    clear_stats();
    start_session(2);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(5);
    tick();
    start      = 1'b0;
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_word(32'h01020304, 1);
    wait_idle();
    check("s6_writes", wr_log.size(), 2);
    check("s6_done_cnt", done_cnt, 1);
    expect_write(0, 0, 32'hDEADBEEF);
    expect_write(1, 1, 32'h01020304);

    // Randomized sessions against the reference model.
    for (int s = 0; s < 40; s++) begin
      if (s == 5) wc = DEPTH;
      else if ($urandom_range(0, 7) == 0) wc = int'($urandom_range(DEPTH + 1, 63));
      else wc = int'($urandom_range(0, 6));
      clear_stats();
      start_session(wc);
      if (wc > DEPTH) begin
        repeat (2) tick();
        continue;
      end
      aborted = 0;
      for (int w = 0; w < wc && !aborted; w++) begin
        if (w > 0 && $urandom_range(0, 24) == 0) begin
          send_byte(8'($urandom), 0);
          reset = 1'b1;
          tick();
          reset = 1'b0;
          aborted = 1;
        end else begin
          send_word($urandom, (s == 5) ? 0 : 2);
        end
      end
      if (!aborted) begin
        wait_idle();
        check("rnd_writes", wr_log.size(), wc);
        check("rnd_done_cnt", done_cnt, 1);
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
